inv_round_tf: RTL and testbench

Inverse AES round transform for the decryption datapath, equivalent-inverse-cipher order: InvShiftRows, then InvSubBytes, then optional InvMixColumns. It is the decrypt-side counterpart of the forward round transform. The inverse S-box is time-multiplexed over `LANES` byte lanes, so one 128-bit state takes `16/LANES` cycles under a start/done handshake. AddRoundKey is outside this block; the key schedule supplies InvMixColumns-transformed middle round keys.

---
 rtl/aes_pkg.sv | 72 +++++++
 rtl/inv_sub_bytes.sv | 102 ++++++++++
 rtl/inv_round_tf.sv | 66 ++++++
 tb/tb_inv_round_tf.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES decrypt-side constants and helpers.
//   INV_SBOX        256-entry inverse S-box, index 0 is the MSB element
//   inv_sbox        byte lookup
//   xtime / gmul    GF(2^8) arithmetic, reduction polynomial 0x11B
//   inv_shift_rows  128-bit InvShiftRows, byte k = b[127-8k -: 8], s[r,c] = byte 4c+r
//   inv_mix_column  one 32-bit column, row 0 in the top byte
//   isb_state_t     FSM encoding of the substitution engine
package aes_pkg;

  localparam int NUM_BYTES = 16;

  typedef enum logic {ST_IDLE, ST_RUN} isb_state_t;

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // InvMixColumns coefficients never exceed 0x0e, so a 4-bit multiplier suffices.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Row r rotates right by r: s'[r,(c+r) mod 4] = s[r,c].
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] b);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*((c+r)%4)+r) -: 8] = b[127-8*(4*c+r) -: 8];
    return o;
  endfunction

  // Row r of the matrix is row 0 {0e,0b,0d,09} rotated right by r.
  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [3:0]  cf [4];
    logic [31:0] o;
    logic [7:0]  acc;
    cf[0] = 4'he; cf[1] = 4'hb; cf[2] = 4'hd; cf[3] = 4'h9;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      acc = '0;
      for (int j = 0; j < 4; j++)
        acc = acc ^ gmul(col[31-8*j -: 8], cf[(j-r+4)%4]);
      o[31-8*r -: 8] = acc;
    end
    return o;
  endfunction

endpackage

// File: rtl/inv_sub_bytes.sv
// inv_sub_bytes: time-multiplexed InvSubBytes over LANES inverse S-boxes.
//   clk, rst_n   clock, async active-low reset
//   start_i      one-cycle request, samples d_i
//   d_i          state to substitute (already InvShiftRows'd)
//   load_o       high in the cycle a start is accepted (load into registers)
//   b_isb_o      substitution register, partial while busy
//   busy_o       substitution in progress
//   done_o       one-cycle pulse after the final group
// Optional macro HEA_INV_RTF_RESTART_EN: start while busy restarts on new data.
module inv_sub_bytes
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [127:0] d_i,
  output logic         load_o,
  output logic [127:0] b_isb_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam int N  = NUM_BYTES / LANES;
  localparam int GW = (N > 1) ? $clog2(N) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_sub_bytes: LANES must be 1, 2, 4, 8 or 16");
  end

  isb_state_t   state_q, state_d;
  logic [GW-1:0] grp_q, grp_d;
  logic [127:0] isb_q, isb_d;
  logic         done_q, done_d;
  logic         restart;
  logic         load;

`ifdef HEA_INV_RTF_RESTART_EN
  assign restart = start_i;
`else
  assign restart = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    isb_d   = isb_q;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          load    = 1'b1;
          isb_d   = d_i;
          grp_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (restart) begin
          // Aborted state is dropped silently: no done for it.
          load  = 1'b1;
          isb_d = d_i;
          grp_d = '0;
        end else begin
          for (int l = 0; l < LANES; l++)
            isb_d[127-8*(LANES*int'(grp_q)+l) -: 8] =
              inv_sbox(isb_q[127-8*(LANES*int'(grp_q)+l) -: 8]);
          if (grp_q == GW'(N-1)) begin
            grp_d   = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            grp_d = grp_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grp_q   <= '0;
      isb_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      isb_q   <= isb_d;
      done_q  <= done_d;
    end
  end

  assign load_o  = load;
  assign b_isb_o = isb_q;
  assign busy_o  = (state_q == ST_RUN);
  assign done_o  = done_q;

endmodule

// File: rtl/inv_round_tf.sv
// inv_round_tf: inverse AES round, InvShiftRows -> InvSubBytes -> InvMixColumns.
//   LANES    inverse S-box instances (1,2,4,8,16); a state takes 16/LANES cycles
//   EN_IMC   1: b_o = InvMixColumns(b_isb_o); 0: b_o = b_isb_o (final round)
//   clk, rst_n   clock, async active-low reset
//   start        one-cycle request, samples b_i
//   b_i          input state
//   b_isr_o      registered InvShiftRows(b_i) captured at start
//   b_isb_o      InvSubBytes register, partial while busy
//   b_o          round output, combinational from b_isb_o
//   busy_o       substitution in progress
//   done_o       one-cycle pulse, b_isb_o/b_o final
// Optional macro HEA_INV_RTF_RESTART_EN: start while busy restarts on new data.
module inv_round_tf
  import aes_pkg::*;
#(
  parameter int LANES  = 4,
  parameter bit EN_IMC = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] b_i,
  output logic [127:0] b_isr_o,
  output logic [127:0] b_isb_o,
  output logic [127:0] b_o,
  output logic         busy_o,
  output logic         done_o
);

  logic [127:0] isr_w;
  logic [127:0] b_isr_q, b_isr_d;
  logic         load;

  assign isr_w = inv_shift_rows(b_i);

  always_comb begin
    b_isr_d = b_isr_q;
    if (load) b_isr_d = isr_w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) b_isr_q <= '0;
    else        b_isr_q <= b_isr_d;
  end

  inv_sub_bytes #(.LANES(LANES)) u_isb (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .d_i     (isr_w),
    .load_o  (load),
    .b_isb_o (b_isb_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always_comb begin
    b_o = b_isb_o;
    if (EN_IMC)
      for (int c = 0; c < 4; c++)
        b_o[127-32*c -: 32] = inv_mix_column(b_isb_o[127-32*c -: 32]);
  end

  assign b_isr_o = b_isr_q;

endmodule

// File: tb/tb_inv_round_tf.sv
// tb_inv_round_tf: scoreboard bench for inv_round_tf.
// Instances 0..4: LANES = 1,2,4,8,16 with EN_IMC=1; instance 5: LANES=4, EN_IMC=0.
// The reference S-box is derived from GF(2^8) inversion plus the forward affine
// map, then inverted, so it shares no table with the design.
module tb_inv_round_tf;

  typedef struct {
    int           inst;
    logic [127:0] isr;
    logic [127:0] isb;
    logic [127:0] o;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic [127:0]       b_i = '0;
  logic [5:0]         start = '0;
  logic [5:0][127:0]  isr, isb, bo;
  logic [5:0]         busy, done;

  logic [7:0] inv_tbl [256];
  exp_t       exp_q [$];
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 6; g++) begin : g_dut
    localparam int LN  = (g < 5) ? (1 << g) : 4;
    localparam bit IMC = (g < 5);
    inv_round_tf #(.LANES(LN), .EN_IMC(IMC)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start[g]), .b_i(b_i),
      .b_isr_o(isr[g]), .b_isb_o(isb[g]), .b_o(bo[g]),
      .busy_o(busy[g]), .done_o(done[g])
    );
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [8:0] t;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      t = {a, 1'b0};
      if (t[8]) t = t ^ 9'h11b;
      a = t[7:0];
    end
    return p;
  endfunction

  function automatic logic [7:0] m_fwd_sbox(input logic [7:0] x);
    logic [7:0] y;
    y = 8'h01;
    for (int i = 0; i < 254; i++) y = m_mul(y, x);
    return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] m_isr(input logic [127:0] x);
    logic [127:0] y;
    y = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        y[127-8*(4*((c+r)%4)+r) -: 8] = x[127-8*(4*c+r) -: 8];
    return y;
  endfunction

  function automatic logic [127:0] m_sub(input logic [127:0] x);
    logic [127:0] y;
    for (int k = 0; k < 16; k++) y[127-8*k -: 8] = inv_tbl[x[127-8*k -: 8]];
    return y;
  endfunction

  function automatic logic [127:0] m_imc(input logic [127:0] x);
    logic [7:0]   cf [4];
    logic [7:0]   acc;
    logic [127:0] y;
    cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int j = 0; j < 4; j++) acc = acc ^ m_mul(x[127-32*c-8*j -: 8], cf[(j-r+4)%4]);
        y[127-32*c-8*r -: 8] = acc;
      end
    return y;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus helpers ----------------
  // Called after a negedge; start is sampled at the next posedge (E0) and
  // the task returns on the negedge after E0.
  task automatic launch(input int g, input logic [127:0] d, input bit push);
    exp_t e;
    b_i = d;
    start[g] = 1'b1;
    if (push) begin
      e.inst = g;
      e.isr  = m_isr(d);
      e.isb  = m_sub(e.isr);
      e.o    = (g < 5) ? m_imc(e.isb) : e.isb;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  // Latency in rising edges after E0 until done is seen; bsy counts the
  // sampled cycles with busy high before done.
  task automatic wait_done(input int g, output int lat, output int bsy, output bit seen);
    lat  = 0;
    seen = 1'b0;
    bsy  = busy[g] ? 1 : 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done[g]) begin
        lat  = i;
        seen = 1'b1;
        break;
      end
      if (busy[g]) bsy++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int lat, bsy; bit seen; exp_t e;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 6; g++) begin
      n_cmp++;
      if ({isr[g], isb[g], bo[g]} !== '0 || busy[g] !== 1'b0 || done[g] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_outs[%0d]: got isr=%h isb=%h o=%h busy=%b done=%b want all 0",
                 g, isr[g], isb[g], bo[g], busy[g], done[g]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    launch(2, {16{8'h63}}, 1'b1);
    wait_done(2, lat, bsy, seen);
    e = exp_q.pop_front();
    n_cmp++;
    if (!seen || lat != 4) begin
      n_bad++; $display("FAIL reset_first_lat: got %0d (seen=%b) want 4", lat, seen);
    end
    n_cmp++;
    if (bo[2] !== '0) begin
      n_bad++; $display("FAIL reset_first_out: got %h want 0", bo[2]);
    end
    n_cmp++;
    if (isb[2] !== e.isb) begin
      n_bad++; $display("FAIL reset_first_isb: got %h want %h", isb[2], e.isb);
    end
  endtask

  task automatic test_zero_imc();
    int lat, bsy; bit seen; exp_t e;
    launch(2, '0, 1'b1);
    wait_done(2, lat, bsy, seen);
    e = exp_q.pop_front();
    n_cmp++;
    if (!seen || isb[2] !== {16{8'h52}} || isb[2] !== e.isb) begin
      n_bad++; $display("FAIL zero_isb: got %h want %h", isb[2], {16{8'h52}});
    end
    n_cmp++;
    if (bo[2] !== {16{8'h52}} || bo[2] !== e.o) begin
      n_bad++; $display("FAIL zero_imc_out: got %h want %h", bo[2], {16{8'h52}});
    end
  endtask

  task automatic test_fips();
    int lat, bsy; bit seen; exp_t e;
    launch(5, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1);
    wait_done(5, lat, bsy, seen);
    e = exp_q.pop_front();
    n_cmp++;
    if (isr[5] !== 128'hd42711aee0bf98f1b8b45de51e415230) begin
      n_bad++; $display("FAIL fips_isr: got %h want d42711aee0bf98f1b8b45de51e415230", isr[5]);
    end
    n_cmp++;
    if (!seen || bo[5] !== 128'h193de3bea0f4e22b9ac68d2ae9f84808) begin
      n_bad++; $display("FAIL fips_out: got %h want 193de3bea0f4e22b9ac68d2ae9f84808", bo[5]);
    end
    n_cmp++;
    if (bo[5] !== e.o || isb[5] !== e.isb) begin
      n_bad++; $display("FAIL fips_model: got %h want %h", bo[5], e.o);
    end
  endtask

  task automatic test_latency_sweep();
    int lat, bsy, n; bit seen; exp_t e;
    for (int g = 0; g < 5; g++) begin
      n = 16 >> g;
      launch(g, rnd128(), 1'b1);
      wait_done(g, lat, bsy, seen);
      e = exp_q.pop_front();
      n_cmp++;
      if (!seen || lat != n) begin
        n_bad++; $display("FAIL sweep_lat[L=%0d]: got %0d (seen=%b) want %0d", 1 << g, lat, seen, n);
      end
      n_cmp++;
      if (bsy != n) begin
        n_bad++; $display("FAIL sweep_busy[L=%0d]: got %0d want %0d", 1 << g, bsy, n);
      end
      n_cmp++;
      if (bo[g] !== e.o || isr[g] !== e.isr) begin
        n_bad++; $display("FAIL sweep_out[L=%0d]: got %h want %h", 1 << g, bo[g], e.o);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, bsy, n, g; bit seen; exp_t e;
    for (int k = 0; k < 2; k++) begin
      g = (k == 0) ? 2 : 4;
      n = 16 >> g;
      launch(g, rnd128(), 1'b1);
      wait_done(g, lat, bsy, seen);
      e = exp_q.pop_front();
      n_cmp++;
      if (!seen || lat != n || bo[g] !== e.o || busy[g] !== 1'b0) begin
        n_bad++; $display("FAIL b2b_first[%0d]: got lat=%0d busy=%b o=%h want lat=%0d busy=0 o=%h",
                          g, lat, busy[g], bo[g], n, e.o);
      end
      // Start while done is high: must be taken at the very next edge.
      launch(g, rnd128(), 1'b1);
      n_cmp++;
      if (busy[g] !== 1'b1 && n > 0) begin
        n_bad++; $display("FAIL b2b_accept[%0d]: got busy=%b want 1", g, busy[g]);
      end
      wait_done(g, lat, bsy, seen);
      e = exp_q.pop_front();
      n_cmp++;
      if (!seen || lat != n || bo[g] !== e.o || isr[g] !== e.isr) begin
        n_bad++; $display("FAIL b2b_second[%0d]: got lat=%0d o=%h want lat=%0d o=%h",
                          g, lat, bo[g], n, e.o);
      end
    end
  endtask

  task automatic test_mid_start();
    int lat, bsy, want_lat; bit seen; exp_t e;
    logic [127:0] d1, d2;
    d1 = rnd128();
    d2 = ~d1;
    launch(0, d1, 1'b1);
    repeat (4) @(negedge clk);
`ifdef HEA_INV_RTF_RESTART_EN
    void'(exp_q.pop_front());
    launch(0, d2, 1'b1);
    want_lat = 16;
`else
    launch(0, d2, 1'b0);
    want_lat = 11;
`endif
    wait_done(0, lat, bsy, seen);
    e = exp_q.pop_front();
    n_cmp++;
    if (!seen || lat != want_lat) begin
      n_bad++; $display("FAIL mid_start_lat: got %0d (seen=%b) want %0d", lat, seen, want_lat);
    end
    n_cmp++;
    if (bo[0] !== e.o || isr[0] !== e.isr) begin
      n_bad++; $display("FAIL mid_start_out: got %h want %h", bo[0], e.o);
    end
  endtask

  task automatic test_mid_reset();
    int lat, bsy, dones; bit seen; exp_t e;
    launch(0, rnd128(), 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({isr[0], isb[0], bo[0]} !== '0 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset_clear: got isr=%h isb=%h busy=%b want 0", isr[0], isb[0], busy[0]);
    end
    void'(exp_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (done[0]) dones++;
    end
    n_cmp++;
    if (dones != 0) begin
      n_bad++; $display("FAIL mid_reset_nodone: got %0d done pulses want 0", dones);
    end
    launch(0, rnd128(), 1'b1);
    wait_done(0, lat, bsy, seen);
    e = exp_q.pop_front();
    n_cmp++;
    if (!seen || lat != 16 || bo[0] !== e.o) begin
      n_bad++; $display("FAIL mid_reset_next: got lat=%0d o=%h want lat=16 o=%h", lat, bo[0], e.o);
    end
  endtask

  initial begin
    for (int x = 0; x < 256; x++) inv_tbl[m_fwd_sbox(8'(x))] = 8'(x);
    test_reset();
    test_zero_imc();
    test_fips();
    test_latency_sweep();
    test_back_to_back();
    test_mid_start();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
